rif_timer_regfile: RTL and testbench

- Register-interface (RIF) slave that sits directly downstream of the AHB-Lite adapter and consumes its rif_* request signals.
- Provides:
  - a read-only ID register
  - control and interrupt-mask registers
  - a W1C interrupt status register fed by hardware event pulses
  - a reloading down-counter timer
  - NUM_SCRATCH scratch registers
- Returns address-validity and registered read data to the adapter, and drives a level interrupt.

---
 rtl/rif_timer_regfile.sv | 220 ++++++++++++++++++++++
 tb/tb_rif_timer_regfile.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rif_timer_regfile.sv
// rif_timer_regfile: register-interface slave with ID, control, interrupt
// mask/status, a reloading down-counter timer and scratch registers.
//
// Ports:
//   HCLK, HRESET     clock and asynchronous active-high reset
//   rif_addr         byte address (bits [1:0] ignored)
//   rif_wr_req       write request, applied at this HCLK edge
//   rif_rd_req       read request, data captured at this HCLK edge
//   rif_wstrb        byte-lane write enables
//   rif_wdata        write data
//   rif_addr_valid   combinational legality of the presented address/access
//   rif_rdata        registered read data (valid the cycle after the request)
//   hw_event         synchronous event pulses feeding IRQ_STAT[NUM_EVENTS:1]
//   irq              registered level interrupt
module rif_timer_regfile #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_SCRATCH = 4,
  parameter int unsigned NUM_EVENTS  = 8,
  parameter logic [31:0] ID_VALUE    = 32'hA5B1_0001
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic [ADDR_WIDTH-1:0]   rif_addr,
  input  logic                    rif_wr_req,
  input  logic                    rif_rd_req,
  input  logic [DATA_WIDTH/8-1:0] rif_wstrb,
  input  logic [DATA_WIDTH-1:0]   rif_wdata,
  output logic                    rif_addr_valid,
  output logic [DATA_WIDTH-1:0]   rif_rdata,
  input  logic [NUM_EVENTS-1:0]   hw_event,
  output logic                    irq
);

  localparam int unsigned IDX_W    = ADDR_WIDTH - 2;
  localparam int unsigned STAT_W   = NUM_EVENTS + 1;
  localparam int unsigned SCR_BASE = 6;
  localparam int unsigned SCR_IW   = (NUM_SCRATCH > 1) ? $clog2(NUM_SCRATCH) : 1;
  localparam int unsigned NBYTES   = DATA_WIDTH / 8;

  // Elaboration-time parameter legality
  if (DATA_WIDTH != 32) begin : g_chk_dw
    $fatal(1, "rif_timer_regfile: only DATA_WIDTH=32 is supported");
  end
  if (NUM_SCRATCH < 1 || NUM_SCRATCH > 8) begin : g_chk_ns
    $fatal(1, "rif_timer_regfile: NUM_SCRATCH must be 1..8");
  end
  if (NUM_EVENTS < 1 || NUM_EVENTS > 31) begin : g_chk_ne
    $fatal(1, "rif_timer_regfile: NUM_EVENTS must be 1..31");
  end

  typedef enum logic {
    T_IDLE = 1'b0,
    T_RUN  = 1'b1
  } tstate_t;

  // Register state
  tstate_t               tstate;
  logic [1:0]            ctrl_q;
  logic [STAT_W-1:0]     mask_q;
  logic [STAT_W-1:0]     stat_q;
  logic [DATA_WIDTH-1:0] load_q;
  logic [DATA_WIDTH-1:0] cnt_q;
  logic [DATA_WIDTH-1:0] scratch_q [NUM_SCRATCH];

  // Decode signals
  logic [IDX_W-1:0]      word_idx;
  logic                  hit_id, hit_ctrl, hit_mask, hit_stat;
  logic                  hit_load, hit_cnt, hit_scr;
  logic [SCR_IW-1:0]     scr_sel;
  logic                  decode_hit;
  logic                  target_ro;
  logic                  wr_en;

  // Write data helpers
  logic [DATA_WIDTH-1:0] wmask;
  logic [DATA_WIDTH-1:0] wdata_m;
  logic [1:0]            ctrl_wr_val;
  logic                  timer_en_next;
  logic                  expire;
  logic [STAT_W-1:0]     stat_clr;
  logic [STAT_W-1:0]     stat_set;
  logic [DATA_WIDTH-1:0] rd_value;

  logic                  unused_ok;
  assign unused_ok = ^rif_addr[1:0];

  // Address decode and access legality
  always_comb begin
    word_idx   = rif_addr[ADDR_WIDTH-1:2];
    hit_id     = (word_idx == IDX_W'(0));
    hit_ctrl   = (word_idx == IDX_W'(1));
    hit_mask   = (word_idx == IDX_W'(2));
    hit_stat   = (word_idx == IDX_W'(3));
    hit_load   = (word_idx == IDX_W'(4));
    hit_cnt    = (word_idx == IDX_W'(5));
    hit_scr    = (word_idx >= IDX_W'(SCR_BASE)) &&
                 (word_idx <  IDX_W'(SCR_BASE + NUM_SCRATCH));
    scr_sel    = SCR_IW'(word_idx - IDX_W'(SCR_BASE));
    decode_hit = hit_id | hit_ctrl | hit_mask | hit_stat |
                 hit_load | hit_cnt | hit_scr;
    target_ro  = hit_id | hit_cnt;
  end

  assign rif_addr_valid = decode_hit & ~(rif_wr_req & target_ro);
  assign wr_en          = rif_wr_req & rif_addr_valid;

  // Byte-lane mask and strobed write data
  always_comb begin
    wmask = '0;
    for (int i = 0; i < NBYTES; i++) begin
      wmask[i*8 +: 8] = {8{rif_wstrb[i]}};
    end
    wdata_m = rif_wdata & wmask;
  end

  // Post-write CTRL value and the timer enable it implies this cycle
  always_comb begin
    ctrl_wr_val   = (ctrl_q & ~wmask[1:0]) | wdata_m[1:0];
    timer_en_next = (wr_en && hit_ctrl) ? ctrl_wr_val[0] : ctrl_q[0];
    expire        = (tstate == T_RUN) && timer_en_next &&
                    (cnt_q == DATA_WIDTH'(0));
  end

  // Status set/clear terms; set dominates clear
  always_comb begin
    stat_clr = (wr_en && hit_stat) ? wdata_m[STAT_W-1:0] : '0;
    stat_set = {hw_event, expire};
  end

  // Read mux; misses return 0
  always_comb begin
    rd_value = '0;
    if (hit_id)   rd_value = DATA_WIDTH'(ID_VALUE);
    if (hit_ctrl) rd_value = DATA_WIDTH'(ctrl_q);
    if (hit_mask) rd_value = DATA_WIDTH'(mask_q);
    if (hit_stat) rd_value = DATA_WIDTH'(stat_q);
    if (hit_load) rd_value = load_q;
    if (hit_cnt)  rd_value = cnt_q;
    if (hit_scr) begin
      for (int k = 0; k < NUM_SCRATCH; k++) begin
        if (scr_sel == SCR_IW'(k)) rd_value = scratch_q[k];
      end
    end
  end

  // CTRL, IRQ_MASK and TIMER_LOAD
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ctrl_q <= '0;
      mask_q <= '0;
      load_q <= '0;
    end else if (wr_en) begin
      if (hit_ctrl) ctrl_q <= ctrl_wr_val;
      if (hit_mask) mask_q <= (mask_q & ~wmask[STAT_W-1:0]) | wdata_m[STAT_W-1:0];
      if (hit_load) load_q <= (load_q & ~wmask) | wdata_m;
    end
  end

  // Scratch registers
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int k = 0; k < NUM_SCRATCH; k++) scratch_q[k] <= '0;
    end else if (wr_en && hit_scr) begin
      for (int k = 0; k < NUM_SCRATCH; k++) begin
        if (scr_sel == SCR_IW'(k)) scratch_q[k] <= (scratch_q[k] & ~wmask) | wdata_m;
      end
    end
  end

  // Interrupt status (W1C with hardware set priority)
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      stat_q <= '0;
    end else begin
      stat_q <= (stat_q & ~stat_clr) | stat_set;
    end
  end

  // Timer FSM: IDLE loads on enable rising; RUN counts down and reloads at 0
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      tstate <= T_IDLE;
      cnt_q  <= '0;
    end else begin
      case (tstate)
        T_IDLE: begin
          if (timer_en_next) begin
            tstate <= T_RUN;
            cnt_q  <= load_q;
          end
        end
        T_RUN: begin
          if (!timer_en_next) begin
            tstate <= T_IDLE;
          end else if (cnt_q == DATA_WIDTH'(0)) begin
            cnt_q <= load_q;
          end else begin
            cnt_q <= cnt_q - DATA_WIDTH'(1);
          end
        end
        default: begin
          tstate <= T_IDLE;
        end
      endcase
    end
  end

  // Registered read data and interrupt
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      rif_rdata <= '0;
      irq       <= 1'b0;
    end else begin
      if (rif_rd_req) rif_rdata <= rd_value;
      irq <= ctrl_q[1] & (|(stat_q & mask_q));
    end
  end

endmodule

// File: tb/tb_rif_timer_regfile.sv
// Self-checking bench for rif_timer_regfile with a register-map reference model.
module tb_rif_timer_regfile;

  localparam int unsigned AW = 12;
  localparam int unsigned NS = 4;
  localparam int unsigned NE = 8;
  localparam logic [31:0] ID = 32'hA5B1_0001;
  localparam logic [31:0] STAT_BITS = 32'h0000_01FF;

  logic          HCLK;
  logic          HRESET;
  logic [AW-1:0] rif_addr;
  logic          rif_wr_req;
  logic          rif_rd_req;
  logic [3:0]    rif_wstrb;
  logic [31:0]   rif_wdata;
  logic          rif_addr_valid;
  logic [31:0]   rif_rdata;
  logic [NE-1:0] hw_event;
  logic          irq;

  rif_timer_regfile #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(32), .NUM_SCRATCH(NS),
    .NUM_EVENTS(NE), .ID_VALUE(ID)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .rif_addr(rif_addr),
    .rif_wr_req(rif_wr_req), .rif_rd_req(rif_rd_req),
    .rif_wstrb(rif_wstrb), .rif_wdata(rif_wdata),
    .rif_addr_valid(rif_addr_valid), .rif_rdata(rif_rdata),
    .hw_event(hw_event), .irq(irq)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] m_ctrl, m_mask, m_stat, m_load, m_cnt, m_rdata;
  logic [31:0] m_scr [NS];
  logic        m_irq;
  logic        exp_valid, obs_valid;

  function automatic bit m_hit(int idx);
    return (idx >= 0 && idx <= 5) || (idx >= 6 && idx < 6 + int'(NS));
  endfunction

  function automatic logic [31:0] m_read(int idx);
    case (idx)
      0: return ID;
      1: return m_ctrl;
      2: return m_mask;
      3: return m_stat;
      4: return m_load;
      5: return m_cnt;
      default: begin
        if (idx >= 6 && idx < 6 + int'(NS)) return m_scr[idx-6];
        return 32'h0;
      end
    endcase
  endfunction

  task automatic model_zero();
    m_ctrl = 0; m_mask = 0; m_stat = 0; m_load = 0; m_cnt = 0;
    m_rdata = 0; m_irq = 0;
    for (int k = 0; k < int'(NS); k++) m_scr[k] = 0;
  endtask

  // One bus cycle: drive after negedge, update model at posedge, return at next negedge
  task automatic cycle(input logic wr, input logic rd, input logic [AW-1:0] addr,
                       input logic [3:0] strb, input logic [31:0] wd,
                       input logic [NE-1:0] ev);
    int idx;
    logic [31:0] wm, clr, old_load, old_cnt;
    logic en_old, en_new, exp_tick, new_irq;
    rif_wr_req = wr; rif_rd_req = rd; rif_addr = addr;
    rif_wstrb = strb; rif_wdata = wd; hw_event = ev;
    idx = int'(addr >> 2);
    exp_valid = m_hit(idx) && !(wr && (idx == 0 || idx == 5));
    #1;
    obs_valid = rif_addr_valid;
    @(posedge HCLK);
    wm = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    if (rd) m_rdata = m_hit(idx) ? m_read(idx) : 32'h0;
    new_irq  = m_ctrl[1] && ((m_stat & m_mask) != 0);
    old_load = m_load; old_cnt = m_cnt;
    en_old   = m_ctrl[0];
    clr      = 0;
    if (wr && exp_valid) begin
      case (idx)
        1: m_ctrl = ((m_ctrl & ~wm) | (wd & wm)) & 32'h3;
        2: m_mask = ((m_mask & ~wm) | (wd & wm)) & STAT_BITS;
        3: clr = wd & wm & STAT_BITS;
        4: m_load = (m_load & ~wm) | (wd & wm);
        default: if (idx >= 6) m_scr[idx-6] = (m_scr[idx-6] & ~wm) | (wd & wm);
      endcase
    end
    en_new = m_ctrl[0];
    exp_tick = 1'b0;
    if (!en_old && en_new) m_cnt = old_load;
    else if (en_old && en_new) begin
      if (old_cnt == 0) begin m_cnt = old_load; exp_tick = 1'b1; end
      else m_cnt = old_cnt - 1;
    end
    m_stat = (m_stat & ~clr) | ({23'h0, ev, 1'b0}) | {31'h0, exp_tick};
    m_irq = new_irq;
    @(negedge HCLK);
    rif_wr_req = 0; rif_rd_req = 0; hw_event = '0;
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    rif_wr_req = 0; rif_rd_req = 0; rif_addr = '0;
    rif_wstrb = '0; rif_wdata = '0; hw_event = '0;
    repeat (2) @(negedge HCLK);
    model_zero();
    HRESET = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (rif_rdata !== 32'h0 || irq !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: rdata=%h irq=%b required rdata=0 irq=0", rif_rdata, irq);
    end
    checks++;
    if (rif_addr_valid !== 1'b1) begin
      errors++; $display("FAIL reset_idle_valid: got %b required 1", rif_addr_valid);
    end
    cycle(0, 1, 12'h000, 4'h0, 0, 0);
    checks++;
    if (rif_rdata !== 32'hA5B1_0001) begin
      errors++; $display("FAIL read_id: got %h required a5b10001", rif_rdata);
    end
    cycle(0, 1, 12'h004, 4'h0, 0, 0);
    checks++;
    if (rif_rdata !== 32'h0) begin
      errors++; $display("FAIL read_ctrl_reset: got %h required 0", rif_rdata);
    end
  endtask

  task automatic test_scratch_strobe();
    cycle(1, 0, 12'h01C, 4'b0011, 32'hDEAD_BEEF, 0);
    cycle(0, 1, 12'h01C, 4'h0, 0, 0);
    checks++;
    if (rif_rdata !== 32'h0000_BEEF || rif_rdata !== m_rdata) begin
      errors++; $display("FAIL scratch_strobe: got %h required 0000beef", rif_rdata);
    end
  endtask

  task automatic test_invalid();
    cycle(1, 0, 12'h000, 4'hF, 32'h1234_5678, 0);
    checks++;
    if (obs_valid !== 1'b0) begin
      errors++; $display("FAIL wr_id_valid: got %b required 0", obs_valid);
    end
    cycle(1, 0, 12'h014, 4'hF, 32'h1234_5678, 0);
    checks++;
    if (obs_valid !== 1'b0) begin
      errors++; $display("FAIL wr_cnt_valid: got %b required 0", obs_valid);
    end
    cycle(0, 1, 12'h014, 4'h0, 0, 0);
    checks++;
    if (rif_rdata !== 32'h0) begin
      errors++; $display("FAIL cnt_unchanged: got %h required 0", rif_rdata);
    end
    cycle(0, 1, 12'h000, 4'h0, 0, 0);
    cycle(0, 1, 12'h3FC, 4'h0, 0, 0);
    checks++;
    if (obs_valid !== 1'b0 || rif_rdata !== 32'h0) begin
      errors++; $display("FAIL rd_3fc: valid=%b rdata=%h required valid=0 rdata=0", obs_valid, rif_rdata);
    end
    cycle(1, 0, 12'h3FC, 4'hF, 32'hFFFF_FFFF, 0);
    checks++;
    if (obs_valid !== 1'b0) begin
      errors++; $display("FAIL wr_3fc_valid: got %b required 0", obs_valid);
    end
  endtask

  task automatic test_timer();
    logic [31:0] seq [5];
    seq[0] = 3; seq[1] = 2; seq[2] = 1; seq[3] = 0; seq[4] = 3;
    cycle(1, 0, 12'h010, 4'hF, 32'd3, 0);
    cycle(1, 0, 12'h004, 4'hF, 32'd1, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 12'h014, 4'h0, 0, 0);
      checks++;
      if (rif_rdata !== seq[i] || rif_rdata !== m_rdata) begin
        errors++; $display("FAIL timer_seq[%0d]: got %0d required %0d", i, rif_rdata, seq[i]);
      end
    end
    cycle(0, 1, 12'h00C, 4'h0, 0, 0);
    checks++;
    if (rif_rdata[0] !== 1'b1) begin
      errors++; $display("FAIL timer_expiry_stat: got %h required bit0=1", rif_rdata);
    end
    cycle(1, 0, 12'h008, 4'hF, 32'd1, 0);
    cycle(1, 0, 12'h004, 4'hF, 32'd3, 0);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL irq_latency: got %b required 0 on enabling edge", irq);
    end
    cycle(0, 0, 12'h000, 4'h0, 0, 0);
    checks++;
    if (irq !== 1'b1 || irq !== m_irq) begin
      errors++; $display("FAIL irq_assert: got %b required 1", irq);
    end
    cycle(1, 0, 12'h004, 4'hF, 32'd0, 0);
    cycle(0, 1, 12'h014, 4'h0, 0, 0);
    cycle(0, 1, 12'h014, 4'h0, 0, 0);
    checks++;
    if (rif_rdata !== m_rdata) begin
      errors++; $display("FAIL timer_freeze: got %0d required %0d", rif_rdata, m_rdata);
    end
    cycle(1, 0, 12'h00C, 4'hF, 32'h1FF, 0);
  endtask

  task automatic test_w1c_vs_event();
    cycle(0, 0, 12'h000, 4'h0, 0, 8'b0000_0100);
    cycle(1, 0, 12'h00C, 4'h1, 32'h8, 8'b0000_0100);
    cycle(0, 1, 12'h00C, 4'h0, 0, 0);
    checks++;
    if (rif_rdata[3] !== 1'b1 || rif_rdata !== m_rdata) begin
      errors++; $display("FAIL w1c_set_wins: got %h required %h", rif_rdata, m_rdata);
    end
    cycle(1, 0, 12'h00C, 4'h1, 32'h8, 0);
    cycle(0, 1, 12'h00C, 4'h0, 0, 0);
    checks++;
    if (rif_rdata[3] !== 1'b0 || rif_rdata !== m_rdata) begin
      errors++; $display("FAIL w1c_clear: got %h required %h", rif_rdata, m_rdata);
    end
  endtask

  task automatic test_back_to_back();
    cycle(1, 1, 12'h018, 4'hF, 32'h1234_5678, 0);
    checks++;
    if (rif_rdata !== m_rdata || obs_valid !== 1'b1) begin
      errors++; $display("FAIL rw_same_edge: got %h/%b required %h/1", rif_rdata, obs_valid, m_rdata);
    end
    cycle(0, 1, 12'h018, 4'h0, 0, 0);
    checks++;
    if (rif_rdata !== 32'h1234_5678) begin
      errors++; $display("FAIL rw_after: got %h required 12345678", rif_rdata);
    end
  endtask

  task automatic test_random();
    int idx;
    logic wr, rd;
    logic [31:0] wd;
    logic [NE-1:0] ev;
    for (int n = 0; n < 400; n++) begin
      idx = int'($urandom_range(0, 12));
      if (idx == 12) idx = 255;
      wr = ($urandom_range(0, 9) < 4);
      rd = ($urandom_range(0, 9) < 6);
      wd = $urandom;
      if (idx == 4) wd = 32'($urandom_range(0, 6));
      if (idx == 1 && $urandom_range(0, 3) != 0) wd = wd | 32'h1;
      ev = ($urandom_range(0, 9) == 0) ? NE'($urandom) : '0;
      cycle(wr, rd, AW'((idx << 2) | int'($urandom_range(0, 3))),
            4'($urandom), wd, ev);
      checks++;
      if (obs_valid !== exp_valid) begin
        errors++; $display("FAIL rnd_valid[%0d]: got %b required %b", n, obs_valid, exp_valid);
      end
      checks++;
      if (rif_rdata !== m_rdata) begin
        errors++; $display("FAIL rnd_rdata[%0d]: got %h required %h", n, rif_rdata, m_rdata);
      end
      checks++;
      if (irq !== m_irq) begin
        errors++; $display("FAIL rnd_irq[%0d]: got %b required %b", n, irq, m_irq);
      end
    end
  endtask

  task automatic test_reset_midcount();
    int budget;
    do_reset();
    cycle(1, 0, 12'h010, 4'hF, 32'd10, 0);
    cycle(1, 0, 12'h008, 4'hF, 32'h2, 0);
    cycle(1, 0, 12'h004, 4'hF, 32'd3, 8'h01);
    budget = 0;
    while (m_cnt != 5 && budget < 40) begin
      cycle(0, 1, 12'h000, 4'h0, 0, 0);
      budget++;
    end
    checks++;
    if (m_cnt != 5 || irq !== 1'b1 || rif_rdata !== ID) begin
      errors++; $display("FAIL midcount_setup: cnt=%0d irq=%b rdata=%h required cnt=5 irq=1 rdata=%h", m_cnt, irq, rif_rdata, ID);
    end
    #2;
    HRESET = 1'b1;
    #1;
    checks++;
    if (rif_rdata !== 32'h0 || irq !== 1'b0) begin
      errors++; $display("FAIL async_reset: rdata=%h irq=%b required 0/0", rif_rdata, irq);
    end
    @(negedge HCLK);
    model_zero();
    HRESET = 1'b0;
    cycle(0, 1, 12'h004, 4'h0, 0, 0);
    checks++;
    if (rif_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_ctrl: got %h required 0", rif_rdata);
    end
    cycle(0, 1, 12'h014, 4'h0, 0, 0);
    cycle(0, 1, 12'h014, 4'h0, 0, 0);
    checks++;
    if (rif_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_cnt: got %h required 0", rif_rdata);
    end
  endtask

  initial begin
    model_zero();
    HRESET = 1'b1;
    rif_wr_req = 0; rif_rd_req = 0; rif_addr = '0;
    rif_wstrb = '0; rif_wdata = '0; hw_event = '0;
    test_reset();
    test_scratch_strobe();
    test_invalid();
    test_timer();
    test_w1c_vs_event();
    test_back_to_back();
    test_random();
    test_reset_midcount();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
